shift_unit_seq: RTL

//  Parametrised multi-cycle shifter for the MIPS datapath; generalises the fixed

---
 rtl/shift_unit_seq_if.sv | 27 ++
 rtl/shift_unit_seq.sv | 112 +++++++++++
 2 files changed

// File: rtl/shift_unit_seq_if.sv
// Valid/ready request and result bundle for shift_unit_seq.
// master drives requests and takes results; slave is the shifter.
interface shift_unit_seq_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   y;
  logic               err;

  modport master (
    output in_valid, a, shamt, mode, out_ready,
    input  in_ready, out_valid, y, err
  );

  modport slave (
    input  in_valid, a, shamt, mode, out_ready,
    output in_ready, out_valid, y, err
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle SLL/SRL/SRA(/ROTR) shifter, at most STEP bits per clock.
// Ports: clk, rst (sync, active-low), bus (slave handshake), busy.
// Define SHIFT_ROTATE_EN to build ROTR; otherwise mode 11 sets err.
module shift_unit_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_unit_seq_if.slave  bus,
  output logic             busy
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int KW      = SHAMT_W + 1;
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   y_shf;
  logic [SHAMT_W-1:0] rem;
  logic [SHAMT_W-1:0] rem_nxt;
  logic [1:0]         mode_q;
  logic               err_q;
  logic               unsup;
  logic [KW-1:0]      k;

  // k = min(rem, STEP); one extra bit so STEP == WIDTH fits
  always_comb begin
    k = STEP_K;
    if ({1'b0, rem} < STEP_K) k = {1'b0, rem};
  end

  // k < WIDTH always, so its low bits carry the full amount
  assign rem_nxt = rem - k[SHAMT_W-1:0];

`ifdef SHIFT_ROTATE_EN
  logic [KW-1:0] rot;
  assign rot   = KW'(WIDTH) - k;
  assign unsup = 1'b0;
`else
  assign unsup = (bus.mode == 2'b11);
`endif

  always_comb begin
    y_shf = y_q;
    unique case (mode_q)
      2'b00: y_shf = y_q << k;
      2'b01: y_shf = y_q >> k;
      2'b10: y_shf = $signed(y_q) >>> k;
`ifdef SHIFT_ROTATE_EN
      2'b11: y_shf = (y_q >> k) | (y_q << rot);
`else
      2'b11: y_shf = y_q;
`endif
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.shamt == '0 || unsup)
            state_d = DONE;
          else
            state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rem_nxt == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      y_q    <= '0;
      rem    <= '0;
      mode_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.in_valid) begin
        y_q    <= bus.a;
        rem    <= bus.shamt;
        mode_q <= bus.mode;
        err_q  <= unsup;
      end else if (state == SHIFT) begin
        y_q <= y_shf;
        rem <= rem_nxt;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.y         = y_q;
  assign bus.err       = err_q;
  assign busy          = (state != IDLE);
endmodule
